// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: turns a synchronous FIFO read port into a valid/ready stream.
//   Absorbs the FIFO's one-cycle read latency in a 3-entry circular buffer so
//   that one word per cycle is sustained with no combinational path from
//   m_ready to fifo_r_en.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            allows new FIFO pops
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid the cycle after a pop
//   fifo_r_en     FIFO read enable (combinational, registered state only)
//   m_valid       output word available
//   m_data        output word (buffer head)
//   m_ready       consumer ready
//   rd_count      delivered-word counter
// Build option: define FIFO_RD_CNT_EN to build the rd_count counter;
//   otherwise rd_count is tied to 0.
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count
);
  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [1:0] head_q, head_d, tail_q, tail_d, occ_q, occ_d;
  logic       inflight_q, inflight_d;
  logic       hs;
  assign m_valid = occ_q != 2'd0;
  assign m_data  = head_q == 2'd2 ? mem_q[2] : head_q == 2'd1 ? mem_q[1] : mem_q[0];
  assign hs      = m_valid && m_ready;
  // Reserve a buffer slot for every word already in flight so capture can never overflow.
  assign fifo_r_en = rst_n && en && !fifo_empty && (({1'b0, occ_q} + {2'b0, inflight_q}) <= 3'd2);
  always_comb begin
    inflight_d = fifo_r_en;
    head_d     = hs ? (head_q == 2'd2 ? 2'd0 : head_q + 2'd1) : head_q;
    tail_d     = inflight_q ? (tail_q == 2'd2 ? 2'd0 : tail_q + 2'd1) : tail_q;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, hs};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < 3; i++)
        if (inflight_q && tail_q == 2'(i)) mem_q[i] <= fifo_rd_data;
    end
  end
`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + CNT_WIDTH'(hs);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: directed self-checking bench for fifo_read_streamer with a behavioural FIFO.
module tb_fifo_read_streamer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_r_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic [15:0] rd_count;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic ovr_en = 1'b0;
  logic ovr_val = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int out_idx = 0;
  int outst = 0;
  int ndel = 0;
  int tgt;

  fifo_read_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = ovr_en ? ovr_val : (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_r_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] e);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef FIFO_RD_CNT_EN
    return 16'(n);
`else
    return 16'(0 * n);
`endif
  endfunction

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic push_table();
    logic [7:0] t [10] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0d, 8'h8d, 8'h65, 8'h12, 8'h01, 8'h0d};
    for (int i = 0; i < 10; i++) push(t[i]);
  endtask

  task automatic step();
    chk("pop_guard", (fifo_r_en && outst == 3) === 1'b0, (fifo_r_en && outst == 3), 0);
    if (m_valid && m_ready) begin
      chk("data_order", m_data === mem[out_idx], m_data, mem[out_idx]);
      out_idx++;
      ndel++;
    end
    outst = outst + int'(fifo_r_en && !fifo_empty) - int'(m_valid && m_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    #2;
    step();
  endtask

  task automatic drain(input int bound);
    tgt = wr_ptr;
    for (int k = 0; k < bound && out_idx < tgt; k++) tick();
    chk("drain_done", out_idx === tgt, out_idx, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    en = 1'b1; m_ready = 1'b1; ovr_en = 1'b1; ovr_val = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_r_en", fifo_r_en === 1'b0, fifo_r_en, 0);
    chk("rst_valid", m_valid === 1'b0, m_valid, 0);
    chk("rst_data", m_data === 8'h00, m_data, 0);
    chk("rst_count", rd_count === 16'h0000, rd_count, 0);
    rst_n = 1'b1; ovr_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("idle_r_en", fifo_r_en === 1'b0, fifo_r_en, 0);
      chk("idle_valid", m_valid === 1'b0, m_valid, 0);
      step();
    end
    ovr_en = 1'b0;
    push_table();
    for (int i = 0; i < 12; i++) begin
      #2;
      chk("stream_r_en", fifo_r_en === (i < 10), fifo_r_en, (i < 10));
      chk("stream_valid", m_valid === (i >= 2), m_valid, (i >= 2));
      if (i == 2) chk("stream_first", m_data === 8'h24, m_data, 8'h24);
      step();
    end
    #2;
    chk("stream_end_valid", m_valid === 1'b0, m_valid, 0);
    chk("stream_delivered", out_idx === 10, out_idx, 10);
    chk("stream_count", rd_count === exp_cnt(10), rd_count, exp_cnt(10));
    step();
    m_ready = 1'b0;
    push_table();
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("bp_r_en", fifo_r_en === (i < 3), fifo_r_en, (i < 3));
      chk("bp_valid", m_valid === (i >= 2), m_valid, (i >= 2));
      if (i >= 2) chk("bp_hold", m_data === 8'h24, m_data, 8'h24);
      step();
    end
    chk("bp_outstanding", outst === 3, outst, 3);
    m_ready = 1'b1;
    drain(40);
    chk("bp_count", rd_count === exp_cnt(20), rd_count, exp_cnt(20));
    for (int i = 0; i < 40; i++) push(8'(i * 37 + 5));
    tgt = wr_ptr;
    for (int k = 0; k < 400 && out_idx < tgt; k++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rand_done", out_idx === 60, out_idx, 60);
    chk("rand_outstanding", outst === 0, outst, 0);
    chk("rand_count", rd_count === exp_cnt(60), rd_count, exp_cnt(60));
    m_ready = 1'b1;
    push(8'hA5); push(8'h5A); push(8'h3C); push(8'hC3); push(8'h77); push(8'hEE);
    tick();
    en = 1'b0;
    #2;
    chk("en_r_en0", fifo_r_en === 1'b0, fifo_r_en, 0);
    chk("en_valid0", m_valid === 1'b0, m_valid, 0);
    step();
    #2;
    chk("en_valid1", m_valid === 1'b1, m_valid, 1);
    chk("en_data1", m_data === 8'hA5, m_data, 8'hA5);
    chk("en_r_en1", fifo_r_en === 1'b0, fifo_r_en, 0);
    step();
    #2;
    chk("en_valid2", m_valid === 1'b0, m_valid, 0);
    chk("en_r_en2", fifo_r_en === 1'b0, fifo_r_en, 0);
    step();
    en = 1'b1;
    drain(30);
    chk("en_count", rd_count === exp_cnt(66), rd_count, exp_cnt(66));
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'hB0 + i));
    repeat (3) tick();
    #2;
    chk("mid_outstanding", outst === 3, outst, 3);
    chk("mid_valid", m_valid === 1'b1, m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid === 1'b0, m_valid, 0);
    chk("mid_rst_data", m_data === 8'h00, m_data, 0);
    chk("mid_rst_r_en", fifo_r_en === 1'b0, fifo_r_en, 0);
    chk("mid_rst_count", rd_count === 16'h0000, rd_count, 0);
    outst = 0; ndel = 0; out_idx = wr_ptr;
    @(posedge clk);
    #1;
    repeat (2) tick();
    rst_n = 1'b1; m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #2;
    chk("post_r_en", fifo_r_en === 1'b1, fifo_r_en, 1);
    chk("post_valid", m_valid === 1'b0, m_valid, 0);
    step();
    drain(30);
    chk("post_count", rd_count === exp_cnt(4), rd_count, exp_cnt(4));
    chk("post_ndel", ndel === 4, ndel, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_read_streamer.md
# fifo_read_streamer

Read-side companion to the synchronous FIFO: drives the FIFO's read enable, absorbs its one-cycle read latency, and presents popped words downstream as a valid/ready stream. It sits between the FIFO's read port (`r_en`, `data_out`, `empty`) and any consumer that applies backpressure. A 3-entry output buffer sustains one word per cycle without a combinational path from `m_ready` to `fifo_r_en`.

## Interface
- `DATA_WIDTH`, 8: word width; matches the FIFO data width.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  when 1, new FIFO pops may be issued.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO `data_out`; valid on the cycle after a pop.
- `fifo_r_en`  out  1  FIFO read enable (combinational).
- `m_valid`  out  1  output word available.
- `m_data`  out  DATA_WIDTH  output word (head of buffer).
- `m_ready`  in  1  consumer accepts when `m_valid && m_ready`.
- `rd_count`  out  CNT_WIDTH  number of delivered words (see Configuration).

## Operation
- FIFO read contract: `fifo_r_en=1` with `fifo_empty=0` at edge N pops one word, and `fifo_rd_data` holds it for the whole cycle after edge N.
- State:
  - `inflight` (1 bit): a pop was issued at the last edge.
  - `occ` (0..3): buffer occupancy, stored as a 3-entry circular buffer with 2-bit head and tail pointers that wrap 2→0.
- Pop rule: `fifo_r_en = rst_n && en && !fifo_empty && (occ + inflight <= 2)`.
  - Uses registered state only.
  - Never depends on `m_ready`.
- Capture: each edge where `inflight=1` writes `fifo_rd_data` at the tail.
- Output:
  - `m_valid = (occ != 0)`.
  - `m_data` = buffer[head].
  - A handshake advances head.
- Occupancy update: capture and handshake on the same edge leave `occ` unchanged, with both pointers advancing.
- Overflow is impossible by construction: worst case is `occ=2`, `inflight=1`, which yields `occ=3`, and pops stall until occupancy drains.
- `en` deassertion:
  - Blocks new pops only.
  - An in-flight word is still captured.
  - Buffered words still drain.
- `m_data` is stable while `m_valid=1` and `m_ready=0`.
- `fifo_empty` rising while `inflight=1` has no effect; the word is still captured.
- Reset mid-operation:
  - All buffered and in-flight words are discarded.
  - The FIFO is assumed to be reset by the same `rst_n`.

## Timing
- Reset values:
  - `m_valid=0`, `m_data=0`, `rd_count=0`, `fifo_r_en=0`.
  - Internally `occ=0`, `inflight=0`, and both pointers 0.
- Latency: `fifo_r_en` high in cycle C gives `m_valid=1` with that word in cycle C+2.
- Throughput: with `m_ready=1` held and the FIFO non-empty, steady state is `occ=1`, `inflight=1`, giving one word per cycle.
- Backpressure: after `m_ready` falls, at most 2 further words are captured, and `fifo_r_en` is 0 from the cycle where `occ+inflight=3`.
- Ordering: words leave in exact FIFO pop order; no loss and no duplication.

## Configuration
- `FIFO_RD_CNT_EN` defined:
  - `rd_count` increments by 1 on every `m_valid && m_ready` edge.
  - The counter wraps modulo 2^CNT_WIDTH.
  - Reset value is 0.
- `FIFO_RD_CNT_EN` undefined:
  - No counter register is built.
  - The `rd_count` port remains and is tied to 0.

## Test plan
- Reset and idle: hold `rst_n=0` for 3 cycles with `fifo_empty=0` → `fifo_r_en=0`, `m_valid=0`, `rd_count=0`. Release with `fifo_empty=1` → no pops.
- Streaming: FIFO holds 10 words 0x24,0x81,0x09,… with `m_ready=1` and `en=1` → first word on `m_data` 2 cycles after the first `fifo_r_en`, then 10 consecutive valid cycles in order, `rd_count=10`.
- Backpressure: `m_ready=0` from the start with 10 words queued → exactly 3 pops, `occ=3`, `m_data=0x24` held stable. Raise `m_ready` → all 10 words delivered in order.
- Random `m_ready` (50%) over 40 words → output sequence equals FIFO write sequence, and `fifo_r_en` never asserts while `occ+inflight=3`.
- `en` drop: deassert `en` the cycle after a pop → that word still appears on `m_valid` and no further pops occur. Reassert `en` → streaming resumes.
- Reset mid-burst: assert `rst_n=0` with `occ=2`, `inflight=1` → all outputs return to 0 asynchronously, and after release the block behaves as after the first reset.
